// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel stopwatch/countdown display mode.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StEnd   = 2'd3
    } state_e;

    localparam logic DirUp = 1'b0;
    localparam logic DirDn = 1'b1;

    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiColon = 8'h3a;
    localparam logic [7:0] AsciiDot   = 8'h2e;
    localparam logic [7:0] AsciiZero  = 8'h30;

    function automatic int unsigned sub_width(input int unsigned tick_hz);
        return (tick_hz > 1) ? $clog2(tick_hz) : 1;
    endfunction

    // Values 0..99 to two ASCII digits, tens in the upper byte.
    function automatic logic [15:0] two_digit(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = v / 7'd10;
        units = v % 7'd10;
        return {AsciiZero + {1'b0, tens}, AsciiZero + {1'b0, units}};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One stopwatch/countdown channel: IDLE/RUN/PAUSE/END state, direction bit and MM:SS.sub value.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned PRESET_MIN = 5,
    parameter int unsigned SubW       = sub_width(TICK_HZ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_tick,
    input  logic            start,
    input  logic            clear,
    input  logic            dir_tgl,
    output logic [1:0]      state,
    output logic            dir,
    output logic [6:0]      min,
    output logic [5:0]      sec,
    output logic [SubW-1:0] sub
);

    localparam logic [SubW-1:0] SubMax    = SubW'(TICK_HZ - 1);
    localparam logic [6:0]      MinMax    = 7'(MAX_MIN);
    localparam logic [6:0]      MinPreset = 7'(PRESET_MIN);

    state_e          state_q, state_d, state_t;
    logic            dir_q, dir_d;
    logic [6:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [SubW-1:0] sub_q, sub_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            dir_q   <= DirUp;
            min_q   <= '0;
            sec_q   <= '0;
            sub_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_t = state_q;
        dir_d   = dir_q;
        min_d   = min_q;
        sec_d   = sec_q;
        sub_d   = sub_q;
        // The tick sees the pre-event state; button events then act on the ticked result.
        if (en_tick && state_q == StRun) begin
            if (dir_q == DirUp) begin
                if (sub_q != SubMax) begin
                    sub_d = sub_q + 1'b1;
                end else if (sec_q != 6'd59) begin
                    sub_d = '0;
                    sec_d = sec_q + 6'd1;
                end else if (min_q != MinMax) begin
                    sub_d = '0;
                    sec_d = '0;
                    min_d = min_q + 7'd1;
                end else begin
                    state_t = StEnd;
                end
            end else begin
                if (sub_q != '0) begin
                    sub_d = sub_q - 1'b1;
                end else if (sec_q != '0) begin
                    sub_d = SubMax;
                    sec_d = sec_q - 6'd1;
                end else if (min_q != '0) begin
                    sub_d = SubMax;
                    sec_d = 6'd59;
                    min_d = min_q - 7'd1;
                end
                if (min_d == '0 && sec_d == '0 && sub_d == '0) begin
                    state_t = StEnd;
                end
            end
        end

        state_d = state_t;
        if (clear && state_t != StRun) begin
            state_d = StIdle;
            min_d   = (dir_q == DirDn) ? MinPreset : '0;
            sec_d   = '0;
            sub_d   = '0;
        end else if (start) begin
            case (state_t)
                StIdle, StPause: state_d = StRun;
                StRun:           state_d = StPause;
                default:         state_d = state_t;
            endcase
        end else if (dir_tgl && state_t == StIdle) begin
            dir_d = ~dir_q;
            min_d = (dir_d == DirDn) ? MinPreset : '0;
            sec_d = '0;
            sub_d = '0;
        end
    end

    always_comb begin
        state = state_q;
        dir   = dir_q;
        min   = min_q;
        sec   = sec_q;
        sub   = sub_q;
    end

endmodule

// File: rtl/multi_timer.sv
// N-channel stopwatch/countdown display mode: button edge detect, channel select and LCD text ROM.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned PRESET_MIN = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_tick,
    input  logic [3:0]      sw_in,
    input  logic [4:0]      index,
    output logic [7:0]      out,
    output logic [3:0]      sel_ch,
    output logic [N_CH-1:0] alarm
);

    localparam int unsigned SubW    = sub_width(TICK_HZ);
    localparam logic [3:0]  SelLast = 4'(N_CH - 1);

    logic [3:0] sw_q, rise;
    logic [3:0] sel_q, sel_d;
    logic [7:0] out_q, out_d;

    logic [1:0]      ch_state [N_CH];
    logic            ch_dir   [N_CH];
    logic [6:0]      ch_min   [N_CH];
    logic [5:0]      ch_sec   [N_CH];
    logic [SubW-1:0] ch_sub   [N_CH];

    assign rise = sw_in & ~sw_q;

    always_comb begin
        sel_d = sel_q;
        if (rise[2]) begin
            sel_d = (sel_q == SelLast) ? '0 : sel_q + 4'd1;
        end
    end

    // Events are steered by the pre-event selection, so a same-cycle select hits the old channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic is_sel;
        assign is_sel = (sel_q == 4'(i));

        timer_channel #(
            .TICK_HZ   (TICK_HZ),
            .MAX_MIN   (MAX_MIN),
            .PRESET_MIN(PRESET_MIN),
            .SubW      (SubW)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en_tick(en_tick),
            .start  (rise[0] && is_sel),
            .clear  (rise[1] && is_sel),
            .dir_tgl(rise[3] && is_sel),
            .state  (ch_state[i]),
            .dir    (ch_dir[i]),
            .min    (ch_min[i]),
            .sec    (ch_sec[i]),
            .sub    (ch_sub[i])
        );

        assign alarm[i] = (ch_state[i] == StEnd);
    end

    state_e          cur_state;
    logic            cur_dir;
    logic [6:0]      cur_min;
    logic [5:0]      cur_sec;
    logic [SubW-1:0] cur_sub;
    logic [6:0]      cur_cc;

    always_comb begin
        cur_state = StIdle;
        cur_dir   = DirUp;
        cur_min   = '0;
        cur_sec   = '0;
        cur_sub   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == 4'(i)) begin
                cur_state = state_e'(ch_state[i]);
                cur_dir   = ch_dir[i];
                cur_min   = ch_min[i];
                cur_sec   = ch_sec[i];
                cur_sub   = ch_sub[i];
            end
        end
        cur_cc = 7'((32'(cur_sub) * 32'd100) / TICK_HZ);
    end

    logic [23:0] st_txt;
    logic [15:0] dir_txt, min_txt, sec_txt, cc_txt;

    always_comb begin
        unique case (cur_state)
            StIdle:  st_txt = "IDL";
            StRun:   st_txt = "RUN";
            StPause: st_txt = "PAU";
            default: st_txt = "END";
        endcase
        dir_txt = (cur_dir == DirDn) ? "DN" : "UP";
        min_txt = two_digit(cur_min);
        sec_txt = two_digit({1'b0, cur_sec});
        cc_txt  = two_digit(cur_cc);

        case (index)
            5'd0:    out_d = "T";
            5'd1:    out_d = AsciiZero + {4'd0, sel_q} + 8'd1;
            5'd3:    out_d = st_txt[23:16];
            5'd4:    out_d = st_txt[15:8];
            5'd5:    out_d = st_txt[7:0];
            5'd7:    out_d = dir_txt[15:8];
            5'd8:    out_d = dir_txt[7:0];
            5'd16:   out_d = min_txt[15:8];
            5'd17:   out_d = min_txt[7:0];
            5'd18:   out_d = AsciiColon;
            5'd19:   out_d = sec_txt[15:8];
            5'd20:   out_d = sec_txt[7:0];
            5'd21:   out_d = AsciiDot;
            5'd22:   out_d = cc_txt[15:8];
            5'd23:   out_d = cc_txt[7:0];
            default: out_d = AsciiSpace;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_q  <= '0;
            sel_q <= '0;
            out_q <= AsciiSpace;
        end else begin
            sw_q  <= sw_in;
            sel_q <= sel_d;
            out_q <= out_d;
        end
    end

    assign out    = out_q;
    assign sel_ch = sel_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: reads the LCD text back through index/out and checks it.
module tb_multi_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_tick;
    logic [3:0] sw_in;
    logic [4:0] index;
    logic [7:0] out;
    logic [3:0] sel_ch;
    logic [3:0] alarm;

    int n_checks = 0;
    int n_err    = 0;
    logic [79:0] s;

    always #5 clk = ~clk;

    multi_timer #(
        .N_CH      (4),
        .TICK_HZ   (100),
        .MAX_MIN   (99),
        .PRESET_MIN(5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en_tick(en_tick),
        .sw_in  (sw_in),
        .index  (index),
        .out    (out),
        .sel_ch (sel_ch),
        .alarm  (alarm)
    );

    task automatic tick(input int n);
        en_tick = 1'b1;
        repeat (n) @(negedge clk);
        en_tick = 1'b0;
    endtask

    task automatic press(input int b);
        sw_in[b] = 1'b1;
        @(negedge clk);
        sw_in[b] = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_str(input int base, input int len, output logic [79:0] r);
        r = '0;
        for (int k = 0; k < len; k++) begin
            index = 5'(base + k);
            @(negedge clk);
            r = {r[71:0], out};
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; en_tick = 1'b0; sw_in = '0; index = 5'd16;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sel_ch !== 4'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", sel_ch); end
        n_checks++;
        if (alarm !== 4'd0) begin n_err++; $display("FAIL reset_alarm: got %b want 0000", alarm); end
        n_checks++;
        if (out !== 8'h20) begin n_err++; $display("FAIL reset_out: got %h want 20", out); end
        rst = 1'b1;
        @(negedge clk);
        read_str(0, 9, s);
        n_checks++;
        if (s !== "T1 IDL UP") begin n_err++; $display("FAIL reset_line1: got '%s' want 'T1 IDL UP'", s); end
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL reset_value: got '%s' want '00:00.00'", s); end
    endtask

    task automatic test_count_up;
        press(0);
        tick(12345);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "02:03.45") begin n_err++; $display("FAIL up_value: got '%s' want '02:03.45'", s); end
        read_str(3, 3, s);
        n_checks++;
        if (s !== "RUN") begin n_err++; $display("FAIL up_state: got '%s' want 'RUN'", s); end
        n_checks++;
        if (sel_ch !== 4'd0 || alarm !== 4'd0) begin
            n_err++; $display("FAIL up_sel_alarm: got sel=%0d alarm=%b want sel=0 alarm=0000", sel_ch, alarm);
        end
        press(0);
        press(1);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL up_clear: got '%s' want '00:00.00'", s); end
    endtask

    task automatic test_countdown;
        press(2);
        n_checks++;
        if (sel_ch !== 4'd1) begin n_err++; $display("FAIL dn_sel: got %0d want 1", sel_ch); end
        press(3);
        read_str(0, 9, s);
        n_checks++;
        if (s !== "T2 IDL DN") begin n_err++; $display("FAIL dn_line1: got '%s' want 'T2 IDL DN'", s); end
        read_str(16, 8, s);
        n_checks++;
        if (s !== "05:00.00") begin n_err++; $display("FAIL dn_preset: got '%s' want '05:00.00'", s); end
        press(0);
        tick(29999);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.01" || alarm !== 4'd0) begin
            n_err++; $display("FAIL dn_last: got '%s' alarm=%b want '00:00.01' alarm=0000", s, alarm);
        end
        tick(1);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL dn_zero: got '%s' want '00:00.00'", s); end
        read_str(3, 3, s);
        n_checks++;
        if (s !== "END" || alarm !== 4'b0010) begin
            n_err++; $display("FAIL dn_end: got '%s' alarm=%b want 'END' alarm=0010", s, alarm);
        end
        press(0);
        read_str(3, 3, s);
        n_checks++;
        if (s !== "END") begin n_err++; $display("FAIL dn_start_in_end: got '%s' want 'END'", s); end
        press(1);
        n_checks++;
        if (alarm !== 4'd0) begin n_err++; $display("FAIL dn_clear_alarm: got %b want 0000", alarm); end
        read_str(3, 3, s);
        n_checks++;
        if (s !== "IDL") begin n_err++; $display("FAIL dn_clear_state: got '%s' want 'IDL'", s); end
        read_str(16, 8, s);
        n_checks++;
        if (s !== "05:00.00") begin n_err++; $display("FAIL dn_reload: got '%s' want '05:00.00'", s); end
    endtask

    task automatic test_hold;
        press(0);
        sw_in[0] = 1'b1;
        repeat (50) @(negedge clk);
        sw_in[0] = 1'b0;
        @(negedge clk);
        read_str(3, 3, s);
        n_checks++;
        if (s !== "PAU") begin n_err++; $display("FAIL hold_state: got '%s' want 'PAU'", s); end
        press(0);
        tick(100);
        press(1);
        read_str(3, 3, s);
        n_checks++;
        if (s !== "RUN") begin n_err++; $display("FAIL clear_in_run_state: got '%s' want 'RUN'", s); end
        read_str(16, 8, s);
        n_checks++;
        if (s !== "04:59.00") begin n_err++; $display("FAIL clear_in_run_value: got '%s' want '04:59.00'", s); end
        press(0);
        press(1);
        press(3);
        read_str(0, 9, s);
        n_checks++;
        if (s !== "T2 IDL UP") begin n_err++; $display("FAIL dir_back_up: got '%s' want 'T2 IDL UP'", s); end
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL dir_reload_up: got '%s' want '00:00.00'", s); end
    endtask

    task automatic test_concurrent;
        press(2);
        press(2);
        n_checks++;
        if (sel_ch !== 4'd3) begin n_err++; $display("FAIL sel_three: got %0d want 3", sel_ch); end
        press(2);
        n_checks++;
        if (sel_ch !== 4'd0) begin n_err++; $display("FAIL sel_wrap: got %0d want 0", sel_ch); end
        press(0);
        press(2);
        press(2);
        press(0);
        tick(500);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:05.00") begin n_err++; $display("FAIL conc_ch2: got '%s' want '00:05.00'", s); end
        press(2);
        press(2);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:05.00") begin n_err++; $display("FAIL conc_ch0: got '%s' want '00:05.00'", s); end
        press(2);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL conc_ch1: got '%s' want '00:00.00'", s); end
    endtask

    task automatic test_same_cycle;
        press(2);
        press(2);
        sw_in[0] = 1'b1; en_tick = 1'b1;
        @(negedge clk);
        sw_in[0] = 1'b0; en_tick = 1'b0;
        @(negedge clk);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.00") begin n_err++; $display("FAIL start_on_tick: got '%s' want '00:00.00'", s); end
        tick(10);
        sw_in[0] = 1'b1; en_tick = 1'b1;
        @(negedge clk);
        sw_in[0] = 1'b0; en_tick = 1'b0;
        @(negedge clk);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "00:00.11") begin n_err++; $display("FAIL stop_on_tick: got '%s' want '00:00.11'", s); end
        read_str(3, 3, s);
        n_checks++;
        if (s !== "PAU") begin n_err++; $display("FAIL stop_on_tick_state: got '%s' want 'PAU'", s); end
        sw_in = 4'b0101;
        @(negedge clk);
        sw_in = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (sel_ch !== 4'd0) begin n_err++; $display("FAIL sel_with_start: got %0d want 0", sel_ch); end
        press(2);
        press(2);
        press(2);
        read_str(3, 3, s);
        n_checks++;
        if (s !== "RUN") begin n_err++; $display("FAIL start_old_channel: got '%s' want 'RUN'", s); end
        press(0);
    endtask

    task automatic test_force_end;
        force dut.g_ch[3].u_ch.min_q = 7'd99;
        force dut.g_ch[3].u_ch.sec_q = 6'd59;
        force dut.g_ch[3].u_ch.sub_q = 7'd98;
        @(negedge clk);
        release dut.g_ch[3].u_ch.min_q;
        release dut.g_ch[3].u_ch.sec_q;
        release dut.g_ch[3].u_ch.sub_q;
        @(negedge clk);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "99:59.98") begin n_err++; $display("FAIL preload: got '%s' want '99:59.98'", s); end
        press(0);
        tick(3);
        read_str(16, 8, s);
        n_checks++;
        if (s !== "99:59.99") begin n_err++; $display("FAIL max_hold: got '%s' want '99:59.99'", s); end
        read_str(3, 3, s);
        n_checks++;
        if (s !== "END" || alarm !== 4'b1000) begin
            n_err++; $display("FAIL max_end: got '%s' alarm=%b want 'END' alarm=1000", s, alarm);
        end
    endtask

    task automatic test_reset_midrun;
        logic [79:0] e;
        index = 5'd16; en_tick = 1'b1; sw_in = 4'b0001; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out !== 8'h20 || sel_ch !== 4'd0 || alarm !== 4'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got out=%h sel=%0d alarm=%b want 20/0/0000", out, sel_ch, alarm);
        end
        rst = 1'b1; en_tick = 1'b0; sw_in = '0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            e = {8'h00, "T", 8'(8'h31 + c), " IDL UP"};
            read_str(0, 9, s);
            n_checks++;
            if (s !== e) begin n_err++; $display("FAIL midrun_line1_ch%0d: got '%s' want '%s'", c, s, e); end
            read_str(16, 8, s);
            n_checks++;
            if (s !== "00:00.00") begin
                n_err++; $display("FAIL midrun_value_ch%0d: got '%s' want '00:00.00'", c, s);
            end
            press(2);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_countdown();
        test_hold();
        test_concurrent();
        test_same_cycle();
        test_force_end();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised N-channel stopwatch/countdown display mode, successor to the single stopwatch mode of the digital clock. It holds `N_CH` independent timers that all advance on a shared centisecond enable and can each count up or count down from a preset. One channel at a time is controlled through `sw_in`. The block serves ASCII characters to the LCD driver through the same `index`/`out` character-fetch convention as the other display modes, and drives one alarm flag per channel.

## Interface
Parameters:
- `N_CH`, 4: number of timer channels; legal range 1..9.
- `TICK_HZ`, 100: `en_tick` pulses per second; sets the sub-second field range 0..TICK_HZ-1.
- `MAX_MIN`, 99: minute field maximum; legal range 1..99.
- `PRESET_MIN`, 5: countdown preset in minutes; legal range 1..MAX_MIN.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `en_tick` in 1: one-`clk`-wide enable pulse at `TICK_HZ`.
- `sw_in` in 4: debounced, active-high buttons. [0] start/stop, [1] clear, [2] next channel, [3] direction toggle.
- `index` in 5: LCD character position. 0..15 is line 1, 16..31 is line 2.
- `out` out 8: ASCII character for `index`, registered.
- `sel_ch` out 4: currently selected channel, 0-based.
- `alarm` out N_CH: bit n is high while channel n is in END.

## Operation
- Button events are rising edges of `sw_in`, detected against a registered copy of the previous value. A held button produces exactly one event.
- Per-channel state has four values: IDLE, RUN, PAUSE, END. Each channel also holds a direction bit (UP/DN) and a value {min, sec, sub}.
- Events act only on the channel selected at the time of the event. Priority is clear > start/stop > direction. The select event is handled independently of the other three.
- Transitions on the selected channel:
  - start in IDLE → RUN; start in RUN → PAUSE; start in PAUSE → RUN; start in END → ignored.
  - clear in IDLE, PAUSE or END → IDLE, with the value reloaded (UP: 00:00.00; DN: PRESET_MIN:00.00). clear in RUN → ignored.
  - direction in IDLE → flip the direction bit and reload the value for the new direction. direction in any other state → ignored.
- select: `sel_ch` increments; it wraps from N_CH-1 to 0.
- Counting, applied to every channel that is in RUN:
  - UP: `sub` increments. sub wraps at TICK_HZ-1 and carries into sec; sec wraps at 59 and carries into min. At MAX_MIN:59.(TICK_HZ-1) the value holds and the state becomes END.
  - DN: mirror borrow chain. When the tick reaches 00:00.00 the state becomes END in the same cycle.
- Display for the selected channel:
  - Positions 0-1: "T" followed by the ASCII digit sel_ch+1.
  - Positions 3-5: "IDL", "RUN", "PAU" or "END".
  - Positions 7-8: "UP" or "DN".
  - Positions 16-23: "MM:SS.cc". For TICK_HZ≠100, cc is sub scaled by 100/TICK_HZ, integer floor.
  - All other positions: 8'h20.

## Timing
- Reset values:
  - Every channel: IDLE, UP, 00:00.00.
  - Edge register: 0.
  - `sel_ch`: 0; `alarm`: 0; `out`: 8'h20.
- Latency:
  - Button edge → state/`sel_ch`/`alarm` update: 1 cycle after the cycle in which `sw_in` rises.
  - `index` → `out`: 1 cycle.
- Same-cycle tick and event: the tick uses the current, pre-event state.
  - start from IDLE or PAUSE on a tick cycle: no count on that cycle.
  - stop on a tick cycle: that tick is counted.
- A select event in the same cycle as another event: the other event applies to the old channel.
- An END reached in the same cycle as a clear on that channel: clear wins, and the channel ends in IDLE.
- `rst` low in mid-run: the reset state applies on the next edge and overrides `en_tick` and `sw_in`.

## Structure
- Package `multi_timer_pkg` holds:
  - the state enum (IDLE=0, RUN=1, PAUSE=2, END=3);
  - the direction encoding;
  - the ASCII constants (space, colon, dot, '0').
- Sub-module `timer_channel`, instantiated N_CH times in a generate loop. Its ports are clk, rst, en_tick, start, clear, dir_tgl, state, dir, min, sec, sub.
- The top level contains the edge detect, channel select, the mux onto the selected channel, and the binary-to-two-digit-ASCII display ROM.

## Test plan
- Reset with UP, start, then 12345 ticks → sel_ch=0; `out` at indices 16..23 reads "02:03.45"; state RUN; alarm=0.
- Channel 1: direction, start, then 30000 ticks → "00:00.00", END, alarm=4'b0010. A following clear gives IDLE, alarm=0 and the display "05:00.00".
- sw_in[0] held high for 50 cycles → exactly one RUN→PAUSE transition. A clear while in RUN is ignored and the value is unchanged.
- sel_ch=3, then select → sel_ch=0. Run channels 0 and 2 concurrently for 500 ticks → both read "00:05.00", and channel 1 stays at 00:00.00.
- Start asserted on an en_tick cycle → value 00:00.00 after that cycle. Stop asserted on an en_tick cycle → that tick is counted.
- UP channel preloaded to 99:59.98 (via force), then 3 ticks → value holds at 99:59.99, state END, alarm bit set. `rst` low mid-run → all channels read IDLE/UP/00:00.00 and `out`=8'h20 on the next edge.
